// File: rtl/noc_packet_injector.sv
// noc_packet_injector: multi-channel packet stimulus engine with payload generation,
// staggered/broadcast starts, completion timeout and status counters.
module noc_packet_injector #(
   parameter int NUM_CH     = 2,
   parameter int TDATAW     = 32,
   parameter int PKT_CNTW   = 16,
   parameter int GAP_CYCLES = 2,
   parameter int TIMEOUT    = 1024
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     ENABLE,
   input  logic [PKT_CNTW-1:0]      NUM_PKT,
   input  logic                     MODE,
   input  logic [TDATAW-1:0]        SEED,
   output logic [NUM_CH-1:0]        START_O,
   output logic [NUM_CH*TDATAW-1:0] DATA_O,
   input  logic                     DONE_I,
   output logic                     BUSY,
   output logic                     FINISHED,
   output logic [PKT_CNTW-1:0]      PKT_SENT,
   output logic                     TIMEOUT_ERR,
   output logic [PKT_CNTW-1:0]      TIMEOUT_CNT
);
   localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int GW  = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
   localparam int TW  = $clog2(TIMEOUT);
   localparam logic [2:0] S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT = 3'd2, S_GAP = 3'd3, S_FIN = 3'd4;

   logic [2:0]               state_q, state_d;
   logic [PKT_CNTW-1:0]      num_q, num_d, sent_q, sent_d, tcnt_q, tcnt_d;
   logic                     mode_q, mode_d, terr_q, terr_d, busy_q, busy_d, fin_q, fin_d;
   logic [TDATAW-1:0]        base_q, base_d;
   logic [CHW-1:0]           ch_q, ch_d;
   logic [GW-1:0]            gap_q, gap_d;
   logic [TW-1:0]            timer_q, timer_d;
   logic [NUM_CH-1:0]        start_q, start_d;
   logic [NUM_CH*TDATAW-1:0] data_q, data_d;
   logic                     go, adv;

   // base_q tracks SEED + pkt_idx*NUM_CH so lanes only add their channel index
   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      mode_d  = mode_q;
      base_d  = base_q;
      ch_d    = ch_q;
      gap_d   = gap_q;
      timer_d = timer_q;
      data_d  = data_q;
      sent_d  = sent_q;
      terr_d  = terr_q;
      tcnt_d  = tcnt_q;
      start_d = '0;
      go      = 1'b0;
      adv     = 1'b0;
      case (state_q)
         S_IDLE: if (ENABLE) begin
            num_d   = NUM_PKT;
            mode_d  = MODE;
            base_d  = SEED;
            sent_d  = '0;
            terr_d  = 1'b0;
            tcnt_d  = '0;
            go      = NUM_PKT != '0;
            state_d = go ? S_ISSUE : S_FIN;
         end
         S_ISSUE:
            if (!ENABLE) state_d = S_IDLE;
            else if (!mode_q && ch_q != CHW'(NUM_CH - 1)) begin
               ch_d = ch_q + CHW'(1);
               adv  = 1'b1;
            end else begin
               state_d = S_WAIT;
               timer_d = '0;
            end
         S_WAIT:
            if (!ENABLE) state_d = S_IDLE;
            else if (DONE_I || timer_q == TW'(TIMEOUT - 1)) begin
               sent_d = &sent_q ? sent_q : sent_q + PKT_CNTW'(1);
               if (!DONE_I) begin
                  terr_d = 1'b1;
                  tcnt_d = &tcnt_q ? tcnt_q : tcnt_q + PKT_CNTW'(1);
               end
               base_d  = base_q + TDATAW'(NUM_CH);
               gap_d   = '0;
               go      = sent_d != num_q && GAP_CYCLES == 0;
               state_d = sent_d == num_q ? S_FIN : go ? S_ISSUE : S_GAP;
            end else timer_d = timer_q + TW'(1);
         S_GAP:
            if (!ENABLE) state_d = S_IDLE;
            else if (gap_q == GW'(GAP_CYCLES - 1)) begin
               go      = 1'b1;
               state_d = S_ISSUE;
            end else gap_d = gap_q + GW'(1);
         S_FIN: if (!ENABLE) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (go) ch_d = '0;
      for (int k = 0; k < NUM_CH; k++)
         if ((go && (mode_d || k == 0)) || (adv && k == int'(ch_d))) begin
            start_d[k] = 1'b1;
            data_d[k*TDATAW +: TDATAW] = base_d + TDATAW'(k);
         end
      busy_d = state_d == S_ISSUE || state_d == S_WAIT || state_d == S_GAP;
      fin_d  = state_d == S_FIN;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         num_q   <= '0;
         mode_q  <= 1'b0;
         base_q  <= '0;
         ch_q    <= '0;
         gap_q   <= '0;
         timer_q <= '0;
         start_q <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         fin_q   <= 1'b0;
         sent_q  <= '0;
         terr_q  <= 1'b0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         mode_q  <= mode_d;
         base_q  <= base_d;
         ch_q    <= ch_d;
         gap_q   <= gap_d;
         timer_q <= timer_d;
         start_q <= start_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         fin_q   <= fin_d;
         sent_q  <= sent_d;
         terr_q  <= terr_d;
         tcnt_q  <= tcnt_d;
      end
   end

   assign START_O     = start_q;
   assign DATA_O      = data_q;
   assign BUSY        = busy_q;
   assign FINISHED    = fin_q;
   assign PKT_SENT    = sent_q;
   assign TIMEOUT_ERR = terr_q;
   assign TIMEOUT_CNT = tcnt_q;
endmodule

// File: tb/tb_noc_packet_injector.sv
// tb_noc_packet_injector: directed checks of the packet injector, two channels, timeout 16.
module tb_noc_packet_injector;
   logic        clk = 1'b0;
   logic        rst, enable, mode, done_i;
   logic [15:0] num_pkt;
   logic [31:0] seed;
   logic [1:0]  start_o;
   logic [63:0] data_o;
   logic        busy, finished, terr;
   logic [15:0] sent, tcnt;
   int          checks = 0;
   int          failures = 0;

   noc_packet_injector #(.NUM_CH(2), .TDATAW(32), .PKT_CNTW(16), .GAP_CYCLES(2), .TIMEOUT(16)) dut (
      .CLK(clk), .RST(rst), .ENABLE(enable), .NUM_PKT(num_pkt), .MODE(mode), .SEED(seed),
      .START_O(start_o), .DATA_O(data_o), .DONE_I(done_i), .BUSY(busy), .FINISHED(finished),
      .PKT_SENT(sent), .TIMEOUT_ERR(terr), .TIMEOUT_CNT(tcnt)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; mode = 1'b0; done_i = 1'b0; num_pkt = '0; seed = '0;
      tick(2);
      rst = 1'b0;
      chk("rst_start", start_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fin", finished, 0);
      chk("rst_sent", sent, 0);
      chk("rst_terr", terr, 0);
      chk("rst_tcnt", tcnt, 0);

      // staggered run, 3 packets, DONE 4 cycles after last start
      num_pkt = 3; mode = 1'b0; seed = 32'h100; enable = 1'b1;
      tick();
      for (int p = 0; p < 3; p++) begin
         chk("stag_start0", start_o, 2'b01);
         chk("stag_lane0", data_o[31:0], 64'h100 + 64'(2*p));
         chk("stag_busy", busy, 1);
         tick();
         chk("stag_start1", start_o, 2'b10);
         chk("stag_lane1", data_o[63:32], 64'h101 + 64'(2*p));
         chk("stag_lane0_hold", data_o[31:0], 64'h100 + 64'(2*p));
         tick(4);
         chk("stag_wait_start", start_o, 0);
         done_i = 1'b1;
         tick();
         done_i = 1'b0;
         chk("stag_sent", sent, 64'(p + 1));
         if (p < 2) begin
            chk("stag_gap0", start_o, 0);
            tick();
            chk("stag_gap1", start_o, 0);
            tick();
         end else begin
            chk("stag_fin", finished, 1);
            chk("stag_fin_busy", busy, 0);
            chk("stag_terr", terr, 0);
         end
      end
      enable = 1'b0;
      tick();
      chk("stag_idle_fin", finished, 0);
      chk("stag_idle_sent", sent, 3);

      // broadcast run, 2 packets
      mode = 1'b1; num_pkt = 2; seed = 0; enable = 1'b1;
      tick();
      chk("bc_start_a", start_o, 2'b11);
      chk("bc_data_a", data_o, {32'd1, 32'd0});
      tick();
      chk("bc_single_a", start_o, 0);
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      chk("bc_sent_a", sent, 1);
      tick(2);
      chk("bc_start_b", start_o, 2'b11);
      chk("bc_data_b", data_o, {32'd3, 32'd2});
      tick();
      chk("bc_single_b", start_o, 0);
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      chk("bc_sent_b", sent, 2);
      chk("bc_fin", finished, 1);
      enable = 1'b0;
      tick();

      // timeouts, DONE held low
      mode = 1'b0; num_pkt = 2; seed = 0; enable = 1'b1;
      tick(3);
      tick(15);
      chk("to_last_wait_sent", sent, 0);
      chk("to_last_wait_terr", terr, 0);
      chk("to_last_wait_busy", busy, 1);
      tick();
      chk("to_sent_a", sent, 1);
      chk("to_cnt_a", tcnt, 1);
      chk("to_err_a", terr, 1);
      tick(4);
      tick(15);
      chk("to_wait_b", finished, 0);
      tick();
      chk("to_sent_b", sent, 2);
      chk("to_cnt_b", tcnt, 2);
      chk("to_err_b", terr, 1);
      chk("to_fin", finished, 1);
      enable = 1'b0;
      tick();

      // DONE during ISSUE ignored; DONE on the 16th wait cycle beats the timeout
      num_pkt = 1; enable = 1'b1;
      tick();
      done_i = 1'b1;
      tick(2);
      done_i = 1'b0;
      chk("race_issue_done_sent", sent, 0);
      chk("race_cnt_cleared", tcnt, 0);
      chk("race_err_cleared", terr, 0);
      tick(15);
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      chk("race_sent", sent, 1);
      chk("race_tcnt", tcnt, 0);
      chk("race_terr", terr, 0);
      chk("race_fin", finished, 1);
      enable = 1'b0;
      tick();

      // zero-packet run
      num_pkt = 0; enable = 1'b1;
      tick();
      chk("zero_fin", finished, 1);
      chk("zero_start", start_o, 0);
      chk("zero_busy", busy, 0);
      tick();
      chk("zero_start_hold", start_o, 0);
      enable = 1'b0;
      tick();

      // payload wrap
      num_pkt = 1; mode = 1'b1; seed = 32'hFFFF_FFFF; enable = 1'b1;
      tick();
      chk("wrap_start", start_o, 2'b11);
      chk("wrap_data", data_o, {32'h0000_0000, 32'hFFFF_FFFF});
      tick();
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      chk("wrap_fin", finished, 1);
      enable = 1'b0;
      tick();

      // abort in WAIT_DONE of packet 2
      mode = 1'b0; num_pkt = 3; seed = 32'h10; enable = 1'b1;
      tick(3);
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      tick(4);
      chk("abort_wait_busy", busy, 1);
      enable = 1'b0;
      tick();
      chk("abort_start", start_o, 0);
      chk("abort_busy", busy, 0);
      chk("abort_fin", finished, 0);
      chk("abort_sent", sent, 1);
      chk("abort_data", data_o, {32'h13, 32'h12});

      // reset mid-run
      seed = 0; enable = 1'b1;
      tick(2);
      chk("mid_start1", start_o, 2'b10);
      rst = 1'b1;
      tick();
      chk("mid_rst_start", start_o, 0);
      chk("mid_rst_data", data_o, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_sent", sent, 0);
      rst = 1'b0; enable = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/noc_packet_injector.md
Name: noc_packet_injector

Overview:
Synthesizable multi-channel packet stimulus engine for the NoC adder test top. Generalises the two-channel START/START2 → wait DONE → gap sequence to NUM_CH channels. Adds deterministic payload generation, staggered or broadcast start modes, a completion timeout, and status counters. Drives the NoC core's per-channel start strobes and input payloads, and consumes its DONE.

Parameters:
NUM_CH, 2, number of injection channels (≥1)
TDATAW, 32, payload width per channel
PKT_CNTW, 16, width of packet count/counters
GAP_CYCLES, 2, idle cycles between DONE and next packet (≥0)
TIMEOUT, 1024, max WAIT_DONE cycles before timeout (≥2)

Ports:
CLK  input  1  single clock
RST  input  1  synchronous, active-high reset
ENABLE  input  1  level; high starts/continues a run, low aborts
NUM_PKT  input  PKT_CNTW  packets per run, latched at run start
MODE  input  1  0 = staggered starts, 1 = broadcast; latched at run start
SEED  input  TDATAW  payload base, latched at run start
START_O  output  NUM_CH  per-channel start strobe
DATA_O  output  NUM_CH*TDATAW  channel k payload at bits [k*TDATAW +: TDATAW]
DONE_I  input  1  completion pulse from NoC core
BUSY  output  1  high in ISSUE/WAIT_DONE/GAP
FINISHED  output  1  high in FIN
PKT_SENT  output  PKT_CNTW  packets completed (DONE or timeout) this run
TIMEOUT_ERR  output  1  sticky; any timeout this run
TIMEOUT_CNT  output  PKT_CNTW  packets closed by timeout this run

Behaviour:
- All outputs registered. RST=1 at an edge forces state IDLE and every output to 0 on the next cycle, including mid-run.
- States: IDLE, ISSUE, WAIT_DONE, GAP, FIN.
- IDLE: ENABLE=1 sampled → latch NUM_PKT/MODE/SEED, clear PKT_SENT/TIMEOUT_ERR/TIMEOUT_CNT, pkt_idx=0. Go to ISSUE, or to FIN if NUM_PKT=0.
- ISSUE, MODE=0: channels 0..NUM_CH-1 in order, one cycle each.
  - START_O = one-hot(k) during channel k's cycle; DATA_O[k] updates in that same cycle.
  - Takes NUM_CH cycles, then WAIT_DONE.
- ISSUE, MODE=1: one cycle with START_O all ones; all DATA_O lanes update together. Then WAIT_DONE.
- Payload: DATA_O[k] = SEED + pkt_idx*NUM_CH + k, mod 2^TDATAW (wraps silently). Lane holds its value until its next update.
- First START_O is high in the cycle immediately after the edge that sampled ENABLE=1 in IDLE.
- WAIT_DONE: timer starts at 0 and increments each cycle; START_O=0.
  - DONE_I=1 → PKT_SENT++.
  - Else timer==TIMEOUT-1 → PKT_SENT++, TIMEOUT_CNT++, TIMEOUT_ERR=1.
  - DONE_I and timer expiry in the same cycle: DONE wins, no timeout recorded.
  - After either, pkt_idx++. Go to FIN if PKT_SENT reaches NUM_PKT, else GAP (or ISSUE directly if GAP_CYCLES=0).
- DONE_I outside WAIT_DONE is ignored; it does not count and is not remembered.
- GAP: exactly GAP_CYCLES cycles with START_O=0, then ISSUE.
- ENABLE=0 sampled in ISSUE/WAIT_DONE/GAP: abort to IDLE next cycle.
  - START_O=0; DATA_O, PKT_SENT and TIMEOUT_* are retained.
- FIN: FINISHED=1, BUSY=0. Stay until ENABLE=0, then IDLE. A new run needs ENABLE low for ≥1 cycle.
- Counters saturate at all-ones; no wrap.

Test Plan:
- NUM_CH=2, GAP=2, MODE=0, NUM_PKT=3, SEED=0x100, DONE_I pulsed 4 cycles after each last start → START_O 01 then 10 per packet. ch0 data 0x100/0x102/0x104, ch1 data 0x101/0x103/0x105. Exactly 2 idle cycles between DONE and next start. PKT_SENT=3, FINISHED=1, TIMEOUT_ERR=0.
- MODE=1, NUM_PKT=2, SEED=0 → START_O=11 for a single cycle per packet. Data (0,1) then (2,3). PKT_SENT=2.
- TIMEOUT=16, NUM_PKT=2, DONE_I held 0 → each packet closes after 16 WAIT_DONE cycles. TIMEOUT_ERR=1, TIMEOUT_CNT=2, PKT_SENT=2, FINISHED=1.
- DONE_I on exactly the 16th WAIT_DONE cycle → TIMEOUT_CNT=0. Same run: DONE_I during ISSUE → no PKT_SENT change.
- NUM_PKT=0 → FINISHED=1 one cycle after ENABLE, START_O never asserted. SEED=0xFFFFFFFF, MODE=1 → ch0=0xFFFFFFFF, ch1=0x00000000.
- ENABLE dropped in WAIT_DONE of packet 2 → IDLE next cycle, START_O=0, PKT_SENT=1 retained. RST=1 mid-run → all outputs 0 next cycle.
